// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter that gives NUM_REQ byte producers
// exclusive, frame-paced access to a single uart_tx instance.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int MAX_GAP = 4095,
  parameter int BUSY_TO = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_data_valid,
  input  logic                 tx_busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;
  localparam int BTO_W = (BUSY_TO > 0) ? $clog2(BUSY_TO + 1) : 1;

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MAX_GAP);
  localparam logic [GAP_W-1:0] GAP_HIT  = GAP_W'(MAX_GAP - 1);
  localparam logic [BTO_W-1:0] BTO_HIT  = BTO_W'(BUSY_TO - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [PTR_W-1:0]   p);
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] cand;
    logic             found;
    sel   = p;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(p) + k) % NUM_REQ);
      if (!found && r[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = {NUM_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] g);
    return (g == LAST_IDX) ? {PTR_W{1'b0}} : g + PTR_W'(1);
  endfunction

  function automatic logic [GAP_W-1:0] gap_inc(input logic [GAP_W-1:0] g);
    return (g == GAP_MAX) ? g : g + GAP_W'(1);
  endfunction

  state_t             state_r,  state_nxt_s;
  logic [PTR_W-1:0]   owner_r,  owner_nxt_s;
  logic [NUM_REQ-1:0] grant_r,  grant_nxt_s;
  logic [NUM_REQ-1:0] ready_r,  ready_nxt_s;
  logic               valid_r,  valid_nxt_s;
  logic [7:0]         data_r,   data_nxt_s;
  logic [PTR_W-1:0]   ptr_r,    ptr_nxt_s;
  logic [GAP_W-1:0]   gap_r,    gap_nxt_s;
  logic [BTO_W-1:0]   bcnt_r,   bcnt_nxt_s;
  logic               last_r,   last_nxt_s;

  logic               sel_req_s;
  logic               sel_last_s;
  logic [7:0]         sel_data_s;
  logic               issue_s;
  logic               gap_hit_s;
  logic               bto_hit_s;

  assign sel_req_s  = req[owner_r];
  assign sel_last_s = req_last[owner_r];
  assign sel_data_s = req_data[{owner_r, 3'b000} +: 8];
  assign issue_s    = sel_req_s & ~tx_busy;
  assign gap_hit_s  = (gap_r == GAP_HIT);
  assign bto_hit_s  = (bcnt_r == BTO_HIT);

  assign req_ready     = ready_r;
  assign grant         = grant_r;
  assign tx_data       = data_r;
  assign tx_data_valid = valid_r;

  // State and registered-output update, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      owner_r <= {PTR_W{1'b0}};
      grant_r <= {NUM_REQ{1'b0}};
      ready_r <= {NUM_REQ{1'b0}};
      valid_r <= 1'b0;
      data_r  <= 8'h00;
      ptr_r   <= {PTR_W{1'b0}};
      gap_r   <= {GAP_W{1'b0}};
      bcnt_r  <= {BTO_W{1'b0}};
      last_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
      grant_r <= grant_nxt_s;
      ready_r <= ready_nxt_s;
      valid_r <= valid_nxt_s;
      data_r  <= data_nxt_s;
      ptr_r   <= ptr_nxt_s;
      gap_r   <= gap_nxt_s;
      bcnt_r  <= bcnt_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (issue_s) begin
          state_nxt_s = ST_WAIT_BUSY;
        end else if (!sel_req_s && gap_hit_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_WAIT_BUSY: begin
        // A missed data_valid never raises busy; time out and carry on.
        if (tx_busy || bto_hit_s) begin
          state_nxt_s = ST_WAIT_DONE;
        end else begin
          state_nxt_s = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt_s = last_r ? ST_IDLE : ST_SEND;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and bookkeeping registers.
  always_comb begin
    owner_nxt_s = owner_r;
    grant_nxt_s = grant_r;
    ready_nxt_s = {NUM_REQ{1'b0}};
    valid_nxt_s = 1'b0;
    data_nxt_s  = data_r;
    ptr_nxt_s   = ptr_r;
    gap_nxt_s   = gap_r;
    bcnt_nxt_s  = bcnt_r;
    last_nxt_s  = last_r;
    case (state_r)
      ST_IDLE: begin
        gap_nxt_s  = {GAP_W{1'b0}};
        bcnt_nxt_s = {BTO_W{1'b0}};
        if (|req) begin
          owner_nxt_s = rr_pick(req, ptr_r);
          grant_nxt_s = to_onehot(rr_pick(req, ptr_r));
        end else begin
          grant_nxt_s = {NUM_REQ{1'b0}};
        end
      end
      ST_SEND: begin
        if (issue_s) begin
          data_nxt_s  = sel_data_s;
          valid_nxt_s = 1'b1;
          ready_nxt_s = to_onehot(owner_r);
          last_nxt_s  = sel_last_s;
          gap_nxt_s   = {GAP_W{1'b0}};
          bcnt_nxt_s  = {BTO_W{1'b0}};
        end else if (!sel_req_s) begin
          // Owner stalled mid-message: revoke once the gap reaches MAX_GAP.
          if (gap_hit_s) begin
            grant_nxt_s = {NUM_REQ{1'b0}};
            ptr_nxt_s   = ptr_after(owner_r);
            gap_nxt_s   = {GAP_W{1'b0}};
          end else begin
            gap_nxt_s = gap_inc(gap_r);
          end
        end else begin
          gap_nxt_s = gap_r;
        end
      end
      ST_WAIT_BUSY: begin
        if (!tx_busy && !bto_hit_s) begin
          bcnt_nxt_s = bcnt_r + BTO_W'(1);
        end else begin
          bcnt_nxt_s = bcnt_r;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy && last_r) begin
          grant_nxt_s = {NUM_REQ{1'b0}};
          ptr_nxt_s   = ptr_after(owner_r);
        end else begin
          grant_nxt_s = grant_r;
        end
      end
      default: begin
        grant_nxt_s = {NUM_REQ{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester/uart_tx stand-ins, a
// specification-level reference model checked every cycle, and literal checks.
module tb_uart_tx_arbiter;

  localparam int N       = 3;
  localparam int MAX_GAP = 10;
  localparam int BUSY_TO = 5;
  localparam int FRAME   = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = {N{1'b0}};
  logic [8*N-1:0] req_data = {8*N{1'b0}};
  logic [N-1:0]   req_last = {N{1'b0}};
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_data_valid;
  logic           tx_busy = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_GAP(MAX_GAP), .BUSY_TO(BUSY_TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .tx_data(tx_data),
    .tx_data_valid(tx_data_valid), .tx_busy(tx_busy)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-requester message buffers: {last, byte}
  logic [8:0] rq_mem [N][64];
  int rq_head [N] = '{default: 0};
  int rq_tail [N] = '{default: 0};

  task automatic push(input int i, input logic [7:0] b, input logic l);
    rq_mem[i][rq_tail[i]] = {l, b};
    rq_tail[i]++;
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (rq_head[i] != rq_tail[i]) e = 1'b0;
    return e;
  endfunction

  // Bytes seen on the uart side
  logic [7:0] log_b [64];
  int log_c [64];
  int n_log    = 0;
  int cyc      = 0;
  int overlaps = 0;
  bit ignore   = 1'b0;
  int busy_cnt = 0;

  // uart_tx stand-in and requesters, all acting on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_data_valid === 1'b1) begin
        if (tx_busy) overlaps++;
        log_b[n_log] = tx_data;
        log_c[n_log] = cyc;
        n_log++;
      end
      if (tx_busy) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end
      if (tx_data_valid === 1'b1 && !ignore) begin
        tx_busy  = 1'b1;
        busy_cnt = FRAME;
      end
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] === 1'b1 && rq_head[i] != rq_tail[i]) rq_head[i]++;
        if (rq_head[i] != rq_tail[i]) begin
          req[i]            = 1'b1;
          req_data[8*i +: 8] = rq_mem[i][rq_head[i]][7:0];
          req_last[i]       = rq_mem[i][rq_head[i]][8];
        end else begin
          req[i]      = 1'b0;
          req_last[i] = 1'b0;
        end
      end
    end
  end

  // Reference model: message owner, rotation pointer, stall run, busy wait
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_phase = 0;
  int         m_run   = 0;
  int         m_timer = 0;
  bit         m_last  = 1'b0;
  logic [N-1:0] e_grant = {N{1'b0}};
  logic [N-1:0] e_ready = {N{1'b0}};
  logic         e_valid = 1'b0;
  logic [7:0]   e_data  = 8'h00;

  task automatic model_step();
    e_ready = {N{1'b0}};
    e_valid = 1'b0;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_phase = 0; m_run = 0; m_timer = 0;
      m_last = 1'b0; e_data = 8'h00;
    end else begin
      case (m_phase)
        0: if (req != {N{1'b0}}) begin
             for (int k = 0; k < N; k++)
               if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
             m_run   = 0;
             m_phase = 1;
           end
        1: if (req[m_owner] && !tx_busy) begin
             e_data           = req_data[8*m_owner +: 8];
             e_valid          = 1'b1;
             e_ready[m_owner] = 1'b1;
             m_last           = req_last[m_owner];
             m_run            = 0;
             m_timer          = 0;
             m_phase          = 2;
           end else if (!req[m_owner]) begin
             m_run++;
             if (m_run == MAX_GAP) begin
               m_ptr = (m_owner + 1) % N; m_owner = -1; m_run = 0; m_phase = 0;
             end
           end
        2: if (tx_busy) m_phase = 3;
           else begin
             m_timer++;
             if (m_timer == BUSY_TO) m_phase = 3;
           end
        3: if (!tx_busy) begin
             if (m_last) begin
               m_ptr = (m_owner + 1) % N; m_owner = -1; m_phase = 0;
             end else m_phase = 1;
           end
        default: m_phase = 0;
      endcase
    end
    e_grant = {N{1'b0}};
    if (m_owner >= 0) e_grant[m_owner] = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("grant", grant, e_grant);
      check("req_ready", req_ready, e_ready);
      check("tx_data_valid", tx_data_valid, e_valid);
      check("tx_data", tx_data, e_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(grant === {N{1'b0}} && all_empty() && !tx_busy) && k < budget) begin
      tick();
      k++;
    end
    check("wait_idle", (k < budget), 1);
  endtask

  task automatic wait_busy(input logic level, input int budget);
    int k = 0;
    while (tx_busy !== level && k < budget) begin
      tick();
      k++;
    end
    check("wait_busy", tx_busy, level);
  endtask

  int base;
  int k;

  initial begin
    repeat (3) tick();
    check("reset_grant", grant, 0);
    check("reset_ready", req_ready, 0);
    check("reset_valid", tx_data_valid, 0);
    check("reset_data", tx_data, 0);
    rst = 1'b0;

    // Single message "AB\n"
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h0A, 1'b1);
    wait_idle(400);
    check("t1_count", n_log, 3);
    check("t1_b0", log_b[0], 8'h41);
    check("t1_b1", log_b[1], 8'h42);
    check("t1_b2", log_b[2], 8'h0A);
    check("t1_grant", grant, 0);

    // Two requesters the cycle after reset: whole messages, 0 first
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = n_log;
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1);
    push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1);
    tick();
    check("t2_grant", grant, 3'b001);
    wait_idle(400);
    check("t2_b0", log_b[base+0], 8'h10);
    check("t2_b1", log_b[base+1], 8'h11);
    check("t2_b2", log_b[base+2], 8'h20);
    check("t2_b3", log_b[base+3], 8'h21);

    // Rotation: pointer past 1 picks 0, pointer past 0 picks 1
    base = n_log;
    push(0, 8'h30, 1'b1); push(1, 8'h31, 1'b1);
    tick();
    check("t3_grant_a", grant, 3'b001);
    wait_idle(400);
    check("t3_b0", log_b[base+0], 8'h30);
    check("t3_b1", log_b[base+1], 8'h31);
    push(0, 8'h32, 1'b1);
    wait_idle(400);
    base = n_log;
    push(0, 8'h33, 1'b1); push(1, 8'h34, 1'b1);
    tick();
    check("t3_grant_b", grant, 3'b010);
    wait_idle(400);
    check("t3_b2", log_b[base+0], 8'h34);
    check("t3_b3", log_b[base+1], 8'h33);

    // Stalled owner loses the grant after MAX_GAP idle cycles
    base = n_log;
    push(0, 8'h55, 1'b0);
    wait_busy(1'b1, 100);
    push(1, 8'h66, 1'b1);
    wait_busy(1'b0, 100);
    k = 0;
    while (grant === 3'b001 && k < 100) begin
      tick();
      k++;
    end
    check("t4_gap_cycles", k, MAX_GAP);
    check("t4_grant_cleared", grant, 0);
    tick();
    check("t4_next_grant", grant, 3'b010);
    wait_idle(400);
    check("t4_count", n_log - base, 2);
    check("t4_b1", log_b[base+1], 8'h66);

    // uart_tx ignores the pulses: busy wait times out, no deadlock
    base = n_log;
    ignore = 1'b1;
    push(0, 8'h31, 1'b0); push(0, 8'h32, 1'b1);
    wait_idle(400);
    ignore = 1'b0;
    check("t5_count", n_log - base, 2);
    check("t5_b1", log_b[base+1], 8'h32);
    check("t5_spacing", log_c[base+1] - log_c[base], BUSY_TO + 2);

    // Reset while a frame is in flight
    base = n_log;
    push(0, 8'h71, 1'b0); push(0, 8'h72, 1'b1);
    wait_busy(1'b1, 100);
    tick();
    rst = 1'b1;
    rq_head[0] = rq_tail[0];
    push(1, 8'h81, 1'b1);
    tick();
    check("t6_grant", grant, 0);
    check("t6_valid", tx_data_valid, 0);
    check("t6_data", tx_data, 0);
    check("t6_busy_held", tx_busy, 1);
    rst = 1'b0;
    wait_idle(400);
    check("t6_count", n_log - base, 2);
    check("t6_b1", log_b[base+1], 8'h81);
    check("no_overlap", overlaps, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
